nios_flash_interface_niosii_oci_dct_packer: RTL and testbench
=============================================================

// Module: nios_flash_interface_NIOSII_oci_dct_packer
// PURPOSE
//   Upstream producer for the OCI trace consumer stage.
//   Packs narrow trace symbols into a 30-bit dct_buffer frame, with a 4-bit
//   dct_count giving the number of valid symbols, and hands each frame off
//   with valid/ready.
//   Sequences end-of-test: drains any residue, then drives test_ending and
//   test_has_ended to the downstream stage.
// PARAMETERS
//   SYM_W  2   bits per trace symbol
//   DEPTH  15  symbols per frame; SYM_W*DEPTH must equal 30; count width 4
// PORTS
//   clk            in   1   single clock; all logic on posedge
//   reset_n        in   1   synchronous, active-low reset
//   sym_valid      in   1   trace symbol present
//   sym_data       in   2   trace symbol
//   sym_ready      out  1   symbol accepted when sym_valid & sym_ready
//   flush          in   1   emit partial frame (one-cycle pulse)
//   test_end_req   in   1   request end-of-test (one-cycle pulse)
//   out_valid      out  1   frame held on dct_buffer/dct_count
//   out_ready      in   1   consumer takes frame when out_valid & out_ready
//   dct_buffer     out  30  symbol k at bits [2k+1:2k]; unused bits 0
//   dct_count      out  4   valid symbols in frame, 1..15
//   test_ending    out  1   end-of-test in progress (sticky)
//   test_has_ended out  1   end-of-test complete (sticky)
//   drop_cnt       out  8   only with OCI_DCT_DROP_EN
// BEHAVIOUR
//   Reset (reset_n low at a clk edge):
//     - accumulator, output register, out_valid, dct_*, test_*, drop_cnt <= 0
//     - pending-flush flag cleared; FSM <= ACCUM
//     - sym_ready = 0 while reset_n = 0
//   Datapath:
//     - Accumulator acc_buf[29:0] / acc_cnt[3:0] feeds output register out_buf.
//     - An accepted symbol is written at slot acc_cnt; acc_cnt increments.
//   Transfer (acc -> out register, same edge):
//     - Condition A: acc_cnt_next == 15, or (flush | flush_pend) with
//       acc_cnt_next > 0.
//     - Condition B: out register free, i.e. !out_valid, or out_valid &
//       out_ready this cycle.
//     - On A & B: out register loads acc, acc clears, out_valid = 1 next cycle.
//     - Latency: the symbol completing a frame appears on dct_buffer the
//       following cycle.
//   Blocked transfer:
//     - A & !B with acc full -> sym_ready = 0.
//     - A & !B from flush -> flush_pend set and held until the transfer fires.
//     - Symbols still enter a non-full acc; these join the pending frame.
//   Boundary rules:
//     - Flush with acc empty and no symbol accepted: no-op, no zero-count frame.
//     - Flush in the same cycle as an accepted symbol: that symbol is included.
//     - out_valid, dct_buffer and dct_count stay stable until consumed.
//     - Back-to-back full frames sustain 1 symbol/cycle when out_ready = 1.
//   FSM ACCUM -> ENDING -> ENDED:
//     - ACCUM: normal operation; test_end_req -> ENDING.
//     - ENDING: sym_ready = 0; test_ending = 1; implicit flush of residue.
//       Move to ENDED when acc_cnt == 0 and out register empty.
//     - ENDED: test_has_ended = 1; both flags held until reset; inputs ignored.
//     - test_end_req in ENDING/ENDED: ignored.
//     - test_end_req together with an accepted symbol: symbol kept and drained.
// CONFIGURATION
//   OCI_DCT_DROP_EN defined:
//     - sym_ready = 1 in ACCUM regardless of backpressure.
//     - A symbol arriving with acc full and transfer blocked is discarded.
//     - Each discard increments drop_cnt, saturating at 255.
//   OCI_DCT_DROP_EN undefined:
//     - drop_cnt port absent; lossless backpressure via sym_ready as above.
// TESTING
//   1 Reset: hold reset_n = 0 for 3 clks with sym_valid = 1 -> all outputs 0,
//     sym_ready = 0; release -> sym_ready = 1.
//   2 Full frame: 15 symbols 2'b01, out_ready = 1 -> next cycle out_valid = 1,
//     dct_buffer = 30'h15555555, dct_count = 15.
//   3 Partial flush: symbols 3,2,1 then flush -> dct_buffer = 30'h0000001B,
//     dct_count = 3; a second flush with empty acc produces no frame.
//   4 Backpressure: out_ready = 0 while 30 symbols are offered -> frame 1
//     held stable, sym_ready = 0 after 30 accepts; out_ready = 1 -> two frames
//     in order, no loss.
//   5 End of test: 5 symbols, then test_end_req -> test_ending = 1 next cycle,
//     frame with count 5, then test_has_ended = 1 one cycle after consume;
//     sym_ready stays 0.
//   6 Drop (OCI_DCT_DROP_EN): out_ready = 0, 40 symbols -> drop_cnt = 10,
//     frames 1-2 intact.

Source files
------------

// File: rtl/nios_flash_interface_niosii_oci_dct_packer.sv
// rtl/nios_flash_interface_niosii_oci_dct_packer.sv - packs 2-bit trace symbols into 30-bit frames and sequences end-of-test
// Optional feature macro: OCI_DCT_DROP_EN (drop symbols on a full, blocked accumulator and count them in drop_cnt)
module nios_flash_interface_niosii_oci_dct_packer #(
    parameter int SYM_W = 2,
    parameter int DEPTH = 15,
    parameter int CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   sym_valid,
    input  logic [SYM_W-1:0]       sym_data,
    output logic                   sym_ready,
    input  logic                   flush,
    input  logic                   test_end_req,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SYM_W*DEPTH-1:0] dct_buffer,
    output logic [CNT_W-1:0]       dct_count,
    output logic                   test_ending,
`ifdef OCI_DCT_DROP_EN
    output logic [7:0]             drop_cnt,
`endif
    output logic                   test_has_ended
);

    localparam int BUF_W = SYM_W * DEPTH;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_ENDING = 2'd1,
        ST_ENDED  = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [BUF_W-1:0]   acc_buf;
    logic [CNT_W-1:0]   acc_cnt;
    logic [BUF_W-1:0]   out_buf;
    logic [CNT_W-1:0]   out_cnt;
    logic               out_valid_q;
    logic               flush_pend;

    logic               in_accum;
    logic               acc_full;
    logic               out_free;
    logic               sym_take;
    logic               sym_store;
    logic               flush_req;
    logic [BUF_W-1:0]   merged_buf;
    logic [CNT_W-1:0]   merged_cnt;
    logic               cond_a;
    logic               xfer;
    logic [BUF_W-1:0]   acc_buf_nx;
    logic [CNT_W-1:0]   acc_cnt_nx;

    assign in_accum = (state == ST_ACCUM);
    assign acc_full = (acc_cnt == FULL_CNT);
    assign out_free = !out_valid_q || out_ready;

`ifdef OCI_DCT_DROP_EN
    assign sym_ready = reset_n && in_accum;
`else
    assign sym_ready = reset_n && in_accum && (!acc_full || out_free);
`endif

    assign sym_take  = sym_valid && sym_ready;
    // A symbol offered to a full, blocked accumulator is only possible in drop mode
    assign sym_store = sym_take && !(acc_full && !out_free);
    assign flush_req = in_accum ? (flush || flush_pend) : (state == ST_ENDING);

    always_comb begin
        merged_buf = acc_buf;
        merged_cnt = acc_cnt;
        if (sym_store && !acc_full) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (acc_cnt == CNT_W'(k)) begin
                    merged_buf[k*SYM_W +: SYM_W] = sym_data;
                end
            end
            merged_cnt = acc_cnt + 1'b1;
        end
    end

    assign cond_a = (merged_cnt == FULL_CNT) || (flush_req && (merged_cnt != '0));
    assign xfer   = cond_a && out_free;

    // When a full accumulator drains and a symbol arrives in the same cycle, it starts the next frame
    always_comb begin
        acc_buf_nx = merged_buf;
        acc_cnt_nx = merged_cnt;
        if (xfer) begin
            acc_buf_nx = '0;
            acc_cnt_nx = '0;
            if (sym_store && acc_full) begin
                acc_buf_nx[SYM_W-1:0] = sym_data;
                acc_cnt_nx            = CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_buf     <= '0;
            acc_cnt     <= '0;
            out_buf     <= '0;
            out_cnt     <= '0;
            out_valid_q <= 1'b0;
            flush_pend  <= 1'b0;
        end else begin
            acc_buf    <= acc_buf_nx;
            acc_cnt    <= acc_cnt_nx;
            flush_pend <= in_accum && flush_req && (acc_cnt_nx != '0);
            if (xfer) begin
                out_buf     <= merged_buf;
                out_cnt     <= merged_cnt;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

`ifdef OCI_DCT_DROP_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if (sym_take && acc_full && !out_free && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_ACCUM;
        end else begin
            state <= state_nx;
        end
    end

    // ENDING completes once the residue is gone and the last frame is leaving this cycle
    always_comb begin
        state_nx = state;
        case (state)
            ST_ACCUM: begin
                if (test_end_req) begin
                    state_nx = ST_ENDING;
                end
            end
            ST_ENDING: begin
                if ((acc_cnt == '0) && (!out_valid_q || out_ready)) begin
                    state_nx = ST_ENDED;
                end
            end
            ST_ENDED: state_nx = ST_ENDED;
            default:  state_nx = ST_ACCUM;
        endcase
    end

    always_comb begin
        test_ending    = (state == ST_ENDING) || (state == ST_ENDED);
        test_has_ended = (state == ST_ENDED);
    end

    assign out_valid  = out_valid_q;
    assign dct_buffer = out_buf;
    assign dct_count  = out_cnt;

endmodule

// File: tb/tb_nios_flash_interface_niosii_oci_dct_packer.sv
// tb/tb_nios_flash_interface_niosii_oci_dct_packer.sv - scoreboard bench for the OCI DCT packer
module tb_nios_flash_interface_niosii_oci_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sym_valid;
    logic [1:0]  sym_data;
    logic        sym_ready;
    logic        flush;
    logic        test_end_req;
    logic        out_valid;
    logic        out_ready;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        test_ending;
    logic        test_has_ended;
`ifdef OCI_DCT_DROP_EN
    logic [7:0]  drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [33:0] exp_q[$];

    logic        hold_prev = 1'b0;
    logic [29:0] prev_buf;
    logic [3:0]  prev_cnt;

    nios_flash_interface_niosii_oci_dct_packer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .sym_valid      (sym_valid),
        .sym_data       (sym_data),
        .sym_ready      (sym_ready),
        .flush          (flush),
        .test_end_req   (test_end_req),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .test_ending    (test_ending),
`ifdef OCI_DCT_DROP_EN
        .drop_cnt       (drop_cnt),
`endif
        .test_has_ended (test_has_ended)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on each handshake and checks held frames stay stable
    always @(negedge clk) begin
        if (!reset_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_buffer", 32'(dct_buffer), 32'(prev_buf));
                check("hold_count", 32'(dct_count), 32'(prev_cnt));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    checks++;
                    $display("FAIL unexpected_frame: got buffer 0x%0h count %0d, none expected", dct_buffer, dct_count);
                end else begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    check("frame_buffer", 32'(dct_buffer), 32'(e[29:0]));
                    check("frame_count", 32'(dct_count), 32'(e[33:30]));
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_buf  = dct_buffer;
            prev_cnt  = dct_count;
        end
    end

    task automatic send(input logic [1:0] d);
        int n;
        sym_valid = 1'b1;
        sym_data  = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sym_ready && n < 50);
        check("send_accept", 32'(sym_ready), 32'd1);
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset_n      = 1'b0;
        sym_valid    = 1'b1;
        sym_data     = 2'd1;
        flush        = 1'b0;
        test_end_req = 1'b0;
        out_ready    = 1'b0;

        // Reset with a symbol offered
        repeat (3) @(posedge clk);
        #1;
        check("rst_sym_ready", 32'(sym_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_buffer", 32'(dct_buffer), 32'd0);
        check("rst_count", 32'(dct_count), 32'd0);
        check("rst_ending", 32'(test_ending), 32'd0);
        check("rst_ended", 32'(test_has_ended), 32'd0);
`ifdef OCI_DCT_DROP_EN
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        reset_n   = 1'b1;
        sym_valid = 1'b0;
        #1;
        check("rel_sym_ready", 32'(sym_ready), 32'd1);

        // Full frame
        out_ready = 1'b1;
        exp_q.push_back({4'd15, 30'h15555555});
        for (int i = 0; i < 15; i++) send(2'b01);
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_count", 32'(dct_count), 32'd15);
        check("full_buffer", 32'(dct_buffer), 32'h15555555);
        drain("full_drain");

        // Partial flush, then a flush with nothing accumulated
        exp_q.push_back({4'd3, 30'h0000001B});
        send(2'd3);
        send(2'd2);
        send(2'd1);
        pulse_flush();
        check("part_valid", 32'(out_valid), 32'd1);
        check("part_buffer", 32'(dct_buffer), 32'h1B);
        drain("part_drain");
        pulse_flush();
        repeat (3) begin
            @(negedge clk);
            check("empty_flush_no_frame", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Flush together with an accepted symbol includes that symbol
        exp_q.push_back({4'd1, 30'h3});
        sym_valid = 1'b1;
        sym_data  = 2'd3;
        flush     = 1'b1;
        @(negedge clk);
        check("same_cycle_ready", 32'(sym_ready), 32'd1);
        @(posedge clk);
        #1;
        sym_valid = 1'b0;
        flush     = 1'b0;
        drain("same_cycle_drain");

        // Backpressure: two full frames with out_ready low
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_q.push_back({4'd15, 30'h24E4E4E4});
        exp_q.push_back({4'd15, 30'h13939393});
        for (int i = 0; i < 30; i++) send(2'(i % 4));
        @(negedge clk);
`ifndef OCI_DCT_DROP_EN
        check("bp_sym_ready", 32'(sym_ready), 32'd0);
`endif
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_buffer", 32'(dct_buffer), 32'h24E4E4E4);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain("bp_drain");

`ifdef OCI_DCT_DROP_EN
        // Drop: 40 symbols into a stalled consumer, last 10 discarded
        out_ready = 1'b0;
        exp_q.push_back({4'd15, 30'h15555555});
        exp_q.push_back({4'd15, 30'h15555555});
        for (int i = 0; i < 40; i++) send(2'b01);
        check("drop_cnt", 32'(drop_cnt), 32'd10);
        out_ready = 1'b1;
        drain("drop_drain");
        check("drop_cnt_hold", 32'(drop_cnt), 32'd10);
`endif

        // End of test with a stalled consumer
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        exp_q.push_back({4'd5, 30'h2AA});
        for (int i = 0; i < 5; i++) send(2'b10);
        test_end_req = 1'b1;
        @(posedge clk);
        #1;
        test_end_req = 1'b0;
        check("end_ending", 32'(test_ending), 32'd1);
        check("end_sym_ready", 32'(sym_ready), 32'd0);
        check("end_not_ended", 32'(test_has_ended), 32'd0);
        begin
            int n;
            n = 0;
            while (!out_valid && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
        end
        check("end_frame_valid", 32'(out_valid), 32'd1);
        check("end_frame_count", 32'(dct_count), 32'd5);
        check("end_wait_ended", 32'(test_has_ended), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("end_consumed", 32'(out_valid), 32'd0);
        check("end_has_ended", 32'(test_has_ended), 32'd1);
        sym_valid    = 1'b1;
        test_end_req = 1'b1;
        flush        = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("ended_sym_ready", 32'(sym_ready), 32'd0);
            check("ended_ending", 32'(test_ending), 32'd1);
            check("ended_flag", 32'(test_has_ended), 32'd1);
            check("ended_no_frame", 32'(out_valid), 32'd0);
        end
        sym_valid    = 1'b0;
        test_end_req = 1'b0;
        flush        = 1'b0;
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
